// File: rtl/register_writeback.sv
// register_writeback
// Write-side register bank of the TD4 datapath. Each executed instruction
// writes one destination (A, B, output port or PC), updates the carry flag
// and advances the program counter. The output port carries a valid/ack
// handshake toward external logic, with a sticky overrun flag that is set
// when unconsumed data gets overwritten.

module register_writeback #(
   parameter logic [3:0] RESET_PC  = 4'b0000,
   parameter logic [3:0] RESET_OUT = 4'b0000
) (
   input  logic       CLK,
   input  logic       N_RESET,
   input  logic       EN,
   input  logic [3:0] Sum,
   input  logic       CarryOut,
   input  logic [1:0] DEST,
   input  logic       JNC,
   input  logic       OutAck,
   output logic [3:0] RegA,
   output logic [3:0] RegB,
   output logic [3:0] OutPort,
   output logic [3:0] PC,
   output logic       CFlag,
   output logic       OutValid,
   output logic       Overrun
);

   localparam logic [1:0] DEST_A   = 2'b00;
   localparam logic [1:0] DEST_B   = 2'b01;
   localparam logic [1:0] DEST_OUT = 2'b10;
   localparam logic [1:0] DEST_PC  = 2'b11;

   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_FULL = 1'b1
   } outState_t;

   logic [3:0] regA_q, regA_d;
   logic [3:0] regB_q, regB_d;
   logic [3:0] outPort_q, outPort_d;
   logic [3:0] pc_q, pc_d;
   logic       cFlag_q, cFlag_d;
   logic       overrun_q, overrun_d;
   outState_t  outState_q, outState_d;

   logic outWrite;
   logic jumpTaken;

   // Decode this cycle's instruction into datapath register updates; the
   // jump condition deliberately uses the registered carry, not CarryOut.
   always_comb begin
      regA_d    = regA_q;
      regB_d    = regB_q;
      outPort_d = outPort_q;
      pc_d      = pc_q;
      cFlag_d   = cFlag_q;
      outWrite  = 1'b0;
      jumpTaken = 1'b0;
      if (EN) begin
         jumpTaken = (DEST == DEST_PC) && (!JNC || !cFlag_q);
         case (DEST)
            DEST_A:   regA_d    = Sum;
            DEST_B:   regB_d    = Sum;
            DEST_OUT: begin
               outPort_d = Sum;
               outWrite  = 1'b1;
            end
            default:  ;
         endcase
         pc_d    = jumpTaken ? Sum : pc_q + 4'd1;
         cFlag_d = CarryOut;
      end
   end

   // Output-port handshake: a write fills the port, an ack without a new
   // write drains it; overwriting unacknowledged data sets the sticky overrun.
   always_comb begin
      outState_d = outState_q;
      overrun_d  = overrun_q;
      case (outState_q)
         OUT_IDLE: begin
            if (outWrite) outState_d = OUT_FULL;
         end
         OUT_FULL: begin
            if (outWrite) begin
               if (!OutAck) overrun_d = 1'b1;
            end else if (OutAck) begin
               outState_d = OUT_IDLE;
            end
         end
         default: outState_d = OUT_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset overriding everything.
   always_ff @(posedge CLK) begin
      if (!N_RESET) begin
         regA_q     <= 4'd0;
         regB_q     <= 4'd0;
         outPort_q  <= RESET_OUT;
         pc_q       <= RESET_PC;
         cFlag_q    <= 1'b0;
         overrun_q  <= 1'b0;
         outState_q <= OUT_IDLE;
      end else begin
         regA_q     <= regA_d;
         regB_q     <= regB_d;
         outPort_q  <= outPort_d;
         pc_q       <= pc_d;
         cFlag_q    <= cFlag_d;
         overrun_q  <= overrun_d;
         outState_q <= outState_d;
      end
   end

   assign RegA     = regA_q;
   assign RegB     = regB_q;
   assign OutPort  = outPort_q;
   assign PC       = pc_q;
   assign CFlag    = cFlag_q;
   assign OutValid = (outState_q == OUT_FULL);
   assign Overrun  = overrun_q;

endmodule
